// File: rtl/key_entry_fsm.sv
`default_nettype none
// ============================================================================
// Module   : key_entry_fsm
// Purpose  : Calculator key-entry sequencer. Collects a first operand, an
//            operator and a second operand from a keypad strobe stream. The
//            operands are accumulated in binary. The completed expression is
//            offered to an ALU with a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   IN_clk        clock, rising edge
//   IN_reset      asynchronous reset, active low
//   IN_key        strobe qualifying IN_value
//   IN_value      key code: 0-9 digit, A-E operator, F equals
//   IN_bksp       backspace strobe
//   IN_clr        clear-all strobe (highest priority)
//   IN_res_valid  IN_res carries the previous ALU result
//   IN_res        previous ALU result, seeds SRC when an operator starts entry
//   IN_ready      ALU accepts the pending expression
//   OUT_SRC       first operand
//   OUT_DST       second operand
//   OUT_ALU_OP    latched operator code (0 = none)
//   OUT_state     IDLE=0, SRC=1, OP=2, DST=3, WAIT=4
//   OUT_count     digits held in the operand being edited
//   OUT_valid     expression complete, held until accepted
//   OUT_ovf       sticky: a digit was dropped at the digit limit
// ============================================================================
module key_entry_fsm #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic                           IN_clk,
    input  logic                           IN_reset,
    input  logic                           IN_key,
    input  logic [3:0]                     IN_value,
    input  logic                           IN_bksp,
    input  logic                           IN_clr,
    input  logic                           IN_res_valid,
    input  logic [WIDTH-1:0]               IN_res,
    input  logic                           IN_ready,
    output logic [WIDTH-1:0]               OUT_SRC,
    output logic [WIDTH-1:0]               OUT_DST,
    output logic [3:0]                     OUT_ALU_OP,
    output logic [2:0]                     OUT_state,
    output logic [$clog2(DIGITS+1)-1:0]    OUT_count,
    output logic                           OUT_valid,
    output logic                           OUT_ovf
);

    localparam int                   c_cnt_w   = $clog2(DIGITS + 1);
    localparam logic [c_cnt_w-1:0]   c_max_cnt = c_cnt_w'(DIGITS);
    localparam logic [c_cnt_w-1:0]   c_one     = c_cnt_w'(1);
    localparam logic [WIDTH-1:0]     c_ten     = WIDTH'(10);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SRC  = 3'd1,
        ST_OP   = 3'd2,
        ST_DST  = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     src_q,   src_d;
    logic [WIDTH-1:0]     dst_q,   dst_d;
    logic [3:0]           op_q,    op_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q,   ovf_d;

    logic                 w_is_digit;
    logic                 w_is_eq;
    logic                 w_bad_state;
    logic [WIDTH-1:0]     w_digit;
    logic [WIDTH-1:0]     w_src_push;
    logic [WIDTH-1:0]     w_dst_push;
    logic [WIDTH-1:0]     w_src_pop;
    logic [WIDTH-1:0]     w_dst_pop;

    assign w_is_digit  = (IN_value <= 4'd9);
    assign w_is_eq     = (IN_value == 4'hF);
    assign w_bad_state = (state_q > ST_WAIT);
    assign w_digit     = WIDTH'(IN_value);

    // Pushes are only taken while count < DIGITS, so the result stays
    // below 10^DIGITS and fits in WIDTH bits.
    assign w_src_push  = src_q * c_ten + w_digit;
    assign w_dst_push  = dst_q * c_ten + w_digit;
    assign w_src_pop   = src_q / c_ten;
    assign w_dst_pop   = dst_q / c_ten;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        op_d    = op_q;
        count_d = count_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;

        // Clear and illegal-encoding recovery share the same all-zero result.
        if (IN_clr || w_bad_state) begin
            state_d = ST_IDLE;
            src_d   = '0;
            dst_d   = '0;
            op_d    = '0;
            count_d = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (IN_key) begin
                        if (w_is_digit) begin
                            src_d   = w_digit;
                            dst_d   = '0;
                            op_d    = '0;
                            count_d = c_one;
                            ovf_d   = 1'b0;
                            state_d = ST_SRC;
                        end else if (!w_is_eq) begin
                            // Operator first: chain from the last ALU result.
                            src_d   = IN_res_valid ? IN_res : '0;
                            op_d    = IN_value;
                            dst_d   = '0;
                            count_d = '0;
                            ovf_d   = 1'b0;
                            state_d = ST_OP;
                        end
                    end
                end

                ST_SRC: begin
                    if (IN_key) begin
                        if (w_is_digit) begin
                            if (count_q < c_max_cnt) begin
                                src_d   = w_src_push;
                                count_d = count_q + c_one;
                            end else begin
                                ovf_d   = 1'b1;
                            end
                        end else if (!w_is_eq) begin
                            op_d    = IN_value;
                            dst_d   = '0;
                            count_d = '0;
                            ovf_d   = 1'b0;
                            state_d = ST_OP;
                        end
                    end else if (IN_bksp && count_q != '0) begin
                        src_d   = w_src_pop;
                        count_d = count_q - c_one;
                        if (count_q == c_one) begin
                            state_d = ST_IDLE;
                        end
                    end
                end

                ST_OP: begin
                    if (IN_key) begin
                        if (w_is_digit) begin
                            dst_d   = w_digit;
                            count_d = c_one;
                            state_d = ST_DST;
                        end else if (!w_is_eq) begin
                            op_d    = IN_value;
                        end
                    end
                end

                ST_DST: begin
                    if (IN_key) begin
                        if (w_is_digit) begin
                            if (count_q < c_max_cnt) begin
                                dst_d   = w_dst_push;
                                count_d = count_q + c_one;
                            end else begin
                                ovf_d   = 1'b1;
                            end
                        end else if (w_is_eq) begin
                            valid_d = 1'b1;
                            state_d = ST_WAIT;
                        end
                    end else if (IN_bksp && count_q != '0) begin
                        dst_d   = w_dst_pop;
                        count_d = count_q - c_one;
                        if (count_q == c_one) begin
                            state_d = ST_OP;
                        end
                    end
                end

                ST_WAIT: begin
                    // Operands and operator are held so the ALU sees a stable
                    // expression; only the handshake can leave this state.
                    if (valid_q && IN_ready) begin
                        valid_d = 1'b0;
                        count_d = '0;
                        state_d = ST_IDLE;
                    end
                end

                default: ;
            endcase
        end
    end

    always_ff @(posedge IN_clk or negedge IN_reset) begin
        if (!IN_reset) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            op_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            op_q    <= op_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign OUT_SRC    = src_q;
    assign OUT_DST    = dst_q;
    assign OUT_ALU_OP = op_q;
    assign OUT_state  = state_q;
    assign OUT_count  = count_q;
    assign OUT_valid  = valid_q;
    assign OUT_ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_key_entry_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_entry_fsm
// Purpose  : Self-checking bench for key_entry_fsm. A behavioural calculator
//            model is compared against the DUT every cycle; directed
//            scenarios add literal expectations, followed by random keys.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_entry_fsm;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 4;
    localparam int CW     = $clog2(DIGITS + 1);

    logic              IN_clk;
    logic              IN_reset;
    logic              IN_key;
    logic [3:0]        IN_value;
    logic              IN_bksp;
    logic              IN_clr;
    logic              IN_res_valid;
    logic [WIDTH-1:0]  IN_res;
    logic              IN_ready;
    logic [WIDTH-1:0]  OUT_SRC;
    logic [WIDTH-1:0]  OUT_DST;
    logic [3:0]        OUT_ALU_OP;
    logic [2:0]        OUT_state;
    logic [CW-1:0]     OUT_count;
    logic              OUT_valid;
    logic              OUT_ovf;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    key_entry_fsm #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .IN_clk       (IN_clk),
        .IN_reset     (IN_reset),
        .IN_key       (IN_key),
        .IN_value     (IN_value),
        .IN_bksp      (IN_bksp),
        .IN_clr       (IN_clr),
        .IN_res_valid (IN_res_valid),
        .IN_res       (IN_res),
        .IN_ready     (IN_ready),
        .OUT_SRC      (OUT_SRC),
        .OUT_DST      (OUT_DST),
        .OUT_ALU_OP   (OUT_ALU_OP),
        .OUT_state    (OUT_state),
        .OUT_count    (OUT_count),
        .OUT_valid    (OUT_valid),
        .OUT_ovf      (OUT_ovf)
    );

    initial IN_clk = 1'b0;
    always #5 IN_clk = ~IN_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural calculator model ----------------
    // Phases: 0 idle, 1 typing first operand, 2 operator chosen,
    //         3 typing second operand, 4 waiting for the ALU.
    int m_phase = 0;
    int m_src   = 0;
    int m_dst   = 0;
    int m_op    = 0;
    int m_cnt   = 0;
    int m_valid = 0;
    int m_ovf   = 0;

    task automatic model_zero();
        m_phase = 0; m_src = 0; m_dst = 0; m_op = 0;
        m_cnt = 0; m_valid = 0; m_ovf = 0;
    endtask

    // Append a decimal digit to a number, honouring the digit limit.
    function automatic int append_digit(int x, int d);
        if (m_cnt < DIGITS) begin
            m_cnt++;
            return x * 10 + d;
        end
        m_ovf = 1;
        return x;
    endfunction

    task automatic start_expression(int op_code);
        m_src = IN_res_valid ? int'(IN_res) : 0;
        m_op = op_code; m_dst = 0; m_cnt = 0; m_ovf = 0; m_phase = 2;
    endtask

    task automatic model_key(int v);
        bit is_digit = (v < 10);
        bit is_eq    = (v == 15);
        if (m_phase == 0) begin
            if (is_digit) begin
                m_src = v; m_dst = 0; m_op = 0; m_cnt = 1; m_ovf = 0; m_phase = 1;
            end else if (!is_eq) begin
                start_expression(v);
            end
        end else if (m_phase == 1) begin
            if (is_digit) m_src = append_digit(m_src, v);
            else if (!is_eq) begin
                m_op = v; m_dst = 0; m_cnt = 0; m_ovf = 0; m_phase = 2;
            end
        end else if (m_phase == 2) begin
            if (is_digit) begin
                m_dst = v; m_cnt = 1; m_phase = 3;
            end else if (!is_eq) m_op = v;
        end else if (m_phase == 3) begin
            if (is_digit) m_dst = append_digit(m_dst, v);
            else if (is_eq) begin
                m_valid = 1; m_phase = 4;
            end
        end
    endtask

    task automatic model_bksp();
        if ((m_phase == 1 || m_phase == 3) && m_cnt > 0) begin
            if (m_phase == 1) m_src = m_src / 10;
            else              m_dst = m_dst / 10;
            m_cnt--;
            if (m_cnt == 0) m_phase = (m_phase == 1) ? 0 : 2;
        end
    endtask

    always @(posedge IN_clk or negedge IN_reset) begin
        if (!IN_reset)            model_zero();
        else if (IN_clr)          model_zero();
        else if (m_phase == 4) begin
            if (m_valid != 0 && IN_ready) begin
                m_valid = 0; m_cnt = 0; m_phase = 0;
            end
        end
        else if (IN_key)          model_key(int'(IN_value));
        else if (IN_bksp)         model_bksp();
    end

    always @(negedge IN_clk) begin
        if (cmp_en) begin
            chk("cyc_state", OUT_state,  m_phase);
            chk("cyc_src",   OUT_SRC,    m_src);
            chk("cyc_dst",   OUT_DST,    m_dst);
            chk("cyc_op",    OUT_ALU_OP, m_op);
            chk("cyc_count", OUT_count,  m_cnt);
            chk("cyc_valid", OUT_valid,  m_valid);
            chk("cyc_ovf",   OUT_ovf,    m_ovf);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic k, input logic [3:0] v, input logic b, input logic c);
        IN_key = k; IN_value = v; IN_bksp = b; IN_clr = c;
        @(posedge IN_clk);
        #1;
        IN_key = 1'b0; IN_bksp = 1'b0; IN_clr = 1'b0;
    endtask

    task automatic press(input logic [3:0] v);
        step(1'b1, v, 1'b0, 1'b0);
    endtask

    task automatic bksp();
        step(1'b0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic clear();
        step(1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, OUT_state, 0);
        chk({tag, "_src"},   OUT_SRC,   0);
        chk({tag, "_dst"},   OUT_DST,   0);
        chk({tag, "_op"},    OUT_ALU_OP, 0);
        chk({tag, "_count"}, OUT_count, 0);
        chk({tag, "_valid"}, OUT_valid, 0);
        chk({tag, "_ovf"},   OUT_ovf,   0);
    endtask

    initial begin
        IN_reset = 1'b0; IN_key = 1'b0; IN_value = 4'd0; IN_bksp = 1'b0;
        IN_clr = 1'b0; IN_res_valid = 1'b0; IN_res = '0; IN_ready = 1'b0;
        repeat (2) @(posedge IN_clk);
        #1;
        chk_all_zero("reset");
        IN_reset = 1'b1;
        cmp_en = 1'b1;

        // Full expression with delayed acceptance.
        press(4'd1); press(4'd2); press(4'd3); press(4'hA);
        press(4'd4); press(4'd5); press(4'hF);
        chk("expr_src",   OUT_SRC,    123);
        chk("expr_dst",   OUT_DST,    45);
        chk("expr_op",    OUT_ALU_OP, 4'hA);
        chk("expr_state", OUT_state,  4);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("expr_valid_held", OUT_valid, 1);
        end
        IN_ready = 1'b1;
        idle();
        IN_ready = 1'b0;
        chk("accept_valid", OUT_valid, 0);
        chk("accept_state", OUT_state, 0);
        chk("accept_src",   OUT_SRC,   123);
        chk("accept_dst",   OUT_DST,   45);
        chk("accept_op",    OUT_ALU_OP, 4'hA);

        // Digit limit and overflow flag.
        clear();
        press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'd5);
        chk("ovf_src",   OUT_SRC,   9876);
        chk("ovf_count", OUT_count, 4);
        chk("ovf_flag",  OUT_ovf,   1);
        press(4'hA);
        chk("ovf_clear", OUT_ovf,   0);
        chk("ovf_state", OUT_state, 2);

        // Backspace.
        clear();
        press(4'd1); press(4'd2); press(4'd3); bksp();
        chk("bk_src",   OUT_SRC,   12);
        chk("bk_count", OUT_count, 2);
        bksp(); bksp();
        chk("bk_src0",  OUT_SRC,   0);
        chk("bk_idle",  OUT_state, 0);
        press(4'hA); press(4'd7); bksp();
        chk("bk_dst_state", OUT_state, 2);
        chk("bk_dst",       OUT_DST,   0);

        // Chaining from a previous result.
        clear();
        IN_res_valid = 1'b1; IN_res = 16'd579;
        press(4'hB);
        IN_res_valid = 1'b0; IN_res = '0;
        chk("chain_src",   OUT_SRC,    579);
        chk("chain_op",    OUT_ALU_OP, 4'hB);
        chk("chain_state", OUT_state,  2);
        press(4'hC);
        chk("chain_op2",   OUT_ALU_OP, 4'hC);

        // Clear beats a simultaneous key.
        clear();
        press(4'd1); press(4'hA); press(4'd2);
        step(1'b1, 4'd5, 1'b0, 1'b1);
        chk_all_zero("clr_key");

        // Asynchronous reset between edges.
        press(4'd1); press(4'hA); press(4'd2);
        #3 IN_reset = 1'b0;
        #1 chk_all_zero("async_rst");
        @(posedge IN_clk);
        #1 IN_reset = 1'b1;
        press(4'd3);
        chk("post_rst_src",   OUT_SRC,   3);
        chk("post_rst_state", OUT_state, 1);

        // Random key traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            logic       k, b, c;
            logic [3:0] v;
            k = ($urandom_range(0, 99) < 50);
            v = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(10, 15))
                                             : 4'($urandom_range(0, 9));
            b = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 99) < 2);
            IN_ready     = ($urandom_range(0, 2) == 0);
            IN_res_valid = $urandom_range(0, 1) != 0;
            IN_res       = 16'($urandom_range(0, 65535));
            step(k, v, b, c);
            if ($urandom_range(0, 399) == 0) begin
                #2 IN_reset = 1'b0;
                #1 chk("rnd_async_rst_src", OUT_SRC, 0);
                @(posedge IN_clk);
                #1 IN_reset = 1'b1;
            end
        end

        IN_ready = 1'b0;
        idle();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
